// File: rtl/param_counter.sv
// Parameterised up/down modulo counter with enable prescaler, saturate/wrap
// boundary handling, terminal-count pulse and sticky boundary flag.
module param_counter #(
   parameter int     WIDTH    = 4,
   parameter longint MODULO   = 16,
   parameter int     PRESCALE = 1
) (
   input  logic             clock,
   input  logic             res_n,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             up,
   input  logic             sat,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf
);

   localparam int               PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]    PRE_TOP = PW'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

   // Prescaler runs as a down-counter: reloaded to PRESCALE-1, step at zero.
   logic [PW-1:0]    pre_cnt;
   logic             pre_tc;
   logic             boundary;
   logic [WIDTH-1:0] load_clip;
   logic [WIDTH-1:0] count_step;

   always_comb begin
      pre_tc    = (pre_cnt == '0);
      boundary  = up ? (count == MAX_VAL) : (count == '0);
      load_clip = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      if (boundary) begin
         if (sat)
            count_step = count;
         else
            count_step = up ? '0 : MAX_VAL;
      end else begin
         count_step = up ? count + 1'b1 : count - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge res_n) begin
      if (!res_n) begin
         count   <= '0;
         pre_cnt <= PRE_TOP;
         tc      <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         tc <= 1'b0;
         if (ovf_clr)
            ovf <= 1'b0;
         if (clr) begin
            count   <= '0;
            pre_cnt <= PRE_TOP;
         end else if (load) begin
            count   <= load_clip;
            pre_cnt <= PRE_TOP;
         end else if (en) begin
            if (pre_tc) begin
               pre_cnt <= PRE_TOP;
               count   <= count_step;
               // a boundary set wins over a same-edge ovf_clr
               if (boundary) begin
                  tc  <= 1'b1;
                  ovf <= 1'b1;
               end
            end else begin
               pre_cnt <= pre_cnt - 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, count register width in bits (legal 1..32).
REQ-002 SHALL have parameter MODULO, default 16, count range 0..MODULO-1 (legal 2..2^WIDTH).
REQ-003 SHALL have parameter PRESCALE, default 1, number of enabled cycles per count step (legal 1..65535).
REQ-004 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port res_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1  count enable; advances the prescaler.
REQ-007 SHALL have port clr  input  1  synchronous clear of count and prescaler.
REQ-008 SHALL have port load  input  1  synchronous load of load_val.
REQ-009 SHALL have port load_val  input  WIDTH  value to load.
REQ-010 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-011 SHALL have port sat  input  1  boundary mode: 1 = saturate, 0 = wrap.
REQ-012 SHALL have port ovf_clr  input  1  synchronous clear of sticky ovf.
REQ-013 SHALL have port count  output  WIDTH  registered count value.
REQ-014 SHALL have port tc  output  1  registered one-cycle terminal-count pulse.
REQ-015 SHALL have port ovf  output  1  registered sticky boundary-hit flag.

Function
REQ-016 Per-edge priority SHALL be clr > load > step; at most one takes effect.
REQ-017 clr=1: count <= 0, prescaler <= 0; tc <= 0; ovf unaffected.
REQ-018 load=1 (clr=0): count <= load_val, or MODULO-1 if load_val >= MODULO; prescaler <= 0; tc <= 0.
REQ-019 Prescaler: internal counter 0..PRESCALE-1, increments only on cycles with en=1 and no clr/load; a step occurs on the edge where en=1 and prescaler==PRESCALE-1, prescaler then returns to 0.
REQ-020 PRESCALE=1 SHALL step on every en=1 cycle; en=0 SHALL freeze count and prescaler.
REQ-021 Non-boundary step: count <= count+1 (up=1) or count-1 (up=0), arithmetic in WIDTH bits.
REQ-022 Boundary = step with up=1 at count==MODULO-1, or up=0 at count==0.
REQ-023 Boundary, sat=0: up wraps to 0, down wraps to MODULO-1.
REQ-024 Boundary, sat=1: count holds its value.
REQ-025 tc SHALL be 1 for exactly the clock cycle following a boundary step edge, else 0; consecutive boundary steps give consecutive tc pulses.
REQ-026 ovf SHALL set on any boundary step and hold until an edge with ovf_clr=1; simultaneous set and ovf_clr SHALL leave ovf=1.
REQ-027 up and sat SHALL be sampled on the step edge only; changes between steps have no effect on count.
REQ-028 Default parameters with en=1, up=1, sat=0, other controls 0 SHALL behave as a free-running 4-bit wrap counter.

Reset
REQ-029 res_n=0 SHALL immediately, without clock, force count=0, prescaler=0, tc=0, ovf=0.
REQ-030 Deassertion of res_n SHALL take effect at the next rising edge; first step no earlier than PRESCALE enabled edges after release.
REQ-031 Reset mid-operation SHALL discard any pending prescaler progress and sticky state.

Verification
REQ-032 Defaults, en=1 up=1 sat=0, 20 edges after reset -> count 1..15,0,1..4; tc high in the cycle count=0 is shown; ovf=1 thereafter.
REQ-033 WIDTH=8 MODULO=10 PRESCALE=3, en=1 up=1 -> count increments every 3rd edge, 9 -> 0 wrap with one tc pulse.
REQ-034 MODULO=10, load_val=200 with load=1 -> count=9; then up=1 sat=1 steps -> count stays 9, tc each step, ovf=1.
REQ-035 count=0, up=0 sat=0, one step -> count=MODULO-1, tc=1 one cycle; ovf_clr=1 on a simultaneous boundary step -> ovf stays 1.
REQ-036 clr=1 and load=1 same edge -> count=0; res_n pulsed low mid-prescale between edges -> count, tc, ovf =0 immediately.
